// File: rtl/vga_mixer_pkg.sv
// Shared constants and address-width helpers for the VGA layer mixer.
package vga_mixer_pkg;

  localparam int          H_ACTIVE_DEF = 640;
  localparam int          V_ACTIVE_DEF = 480;
  localparam int          BG_SHIFT_DEF = 0;
  localparam int          SPR_W_DEF    = 64;
  localparam int          SPR_H_DEF    = 64;
  localparam logic [11:0] KEY_DEF      = 12'hF0F;

  function automatic int bg_aw_f(int h_act, int v_act, int shift);
    return $clog2((h_act >> shift) * (v_act >> shift));
  endfunction

  function automatic int spr_aw_f(int w, int h);
    return $clog2(w * h);
  endfunction

  localparam int BG_AW  = bg_aw_f(H_ACTIVE_DEF, V_ACTIVE_DEF, BG_SHIFT_DEF);
  localparam int SPR_AW = spr_aw_f(SPR_W_DEF, SPR_H_DEF);

endpackage

// File: rtl/vga_sprite_unit.sv
// One sprite layer: frame-boundary shadow registers, hit test and ROM address.
module vga_sprite_unit
  import vga_mixer_pkg::*;
#(
  parameter int SPR_W  = SPR_W_DEF,
  parameter int SPR_H  = SPR_H_DEF,
  parameter int ADDR_W = spr_aw_f(SPR_W, SPR_H)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [9:0]        x_i,
  input  logic [9:0]        y_i,
  input  logic [9:0]        h_i,
  input  logic [9:0]        v_i,
  output logic              hit_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic [9:0]        x_q, y_q;
  logic              en_q;
  logic              hit_q, hit_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [10:0]       h_ext, v_ext, x_ext, y_ext;
  logic              in_x, in_y;

  // 11-bit compares keep x+SPR_W from wrapping, so edge sprites clip cleanly
  assign h_ext = {1'b0, h_i};
  assign v_ext = {1'b0, v_i};
  assign x_ext = {1'b0, x_q};
  assign y_ext = {1'b0, y_q};

  always_comb begin
    in_x   = (h_ext >= x_ext) && (h_ext < x_ext + 11'(SPR_W));
    in_y   = (v_ext >= y_ext) && (v_ext < y_ext + 11'(SPR_H));
    hit_d  = en_q && in_x && in_y;
    addr_d = '0;
    if (hit_d)
      addr_d = ADDR_W'((32'(v_i) - 32'(y_q)) * 32'(SPR_W) + (32'(h_i) - 32'(x_q)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q    <= '0;
      y_q    <= '0;
      en_q   <= 1'b0;
      hit_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      if (load_i) begin
        x_q  <= x_i;
        y_q  <= y_i;
        en_q <= en_i;
      end
      hit_q  <= hit_d;
      addr_q <= addr_d;
    end
  end

  assign hit_o  = hit_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/vga_layer_mixer.sv
// Two-stage background + sprite compositor: stage 1 forms ROM addresses and
// hit flags, stage 2 picks the lowest-index opaque sprite over the background.
module vga_layer_mixer
  import vga_mixer_pkg::*;
#(
  parameter int                 COLOR_W  = 12,
  parameter int                 H_ACTIVE = H_ACTIVE_DEF,
  parameter int                 V_ACTIVE = V_ACTIVE_DEF,
  parameter int                 BG_SHIFT = BG_SHIFT_DEF,
  parameter int                 N_SPR    = 2,
  parameter int                 SPR_W    = SPR_W_DEF,
  parameter int                 SPR_H    = SPR_H_DEF,
  parameter logic [COLOR_W-1:0] KEY      = COLOR_W'(KEY_DEF)
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           bright,
  input  logic [9:0]                                     hCount,
  input  logic [9:0]                                     vCount,
  input  logic [N_SPR*10-1:0]                            spr_x,
  input  logic [N_SPR*10-1:0]                            spr_y,
  input  logic [N_SPR-1:0]                               spr_en,
  output logic [bg_aw_f(H_ACTIVE, V_ACTIVE, BG_SHIFT)-1:0] bg_addr,
  input  logic [COLOR_W-1:0]                             bg_data,
  output logic [N_SPR*spr_aw_f(SPR_W, SPR_H)-1:0]        spr_addr,
  input  logic [N_SPR*COLOR_W-1:0]                       spr_data,
  output logic [COLOR_W-1:0]                             rgb,
  output logic                                           frame_tick
);

  localparam int BG_ADDR_W  = bg_aw_f(H_ACTIVE, V_ACTIVE, BG_SHIFT);
  localparam int SPR_ADDR_W = spr_aw_f(SPR_W, SPR_H);

  logic                 load_shadow;
  logic [BG_ADDR_W-1:0] bg_addr_q, bg_addr_d;
  logic                 bright_q;
  logic                 frame_tick_q;
  logic [N_SPR-1:0]     hit;
  logic [COLOR_W-1:0]   rgb_q, rgb_d;

  // Shadow load happens on the first blanking line so a whole frame sees one position set
  assign load_shadow = (hCount == 10'd0) && (vCount == 10'(V_ACTIVE));

  assign bg_addr_d = BG_ADDR_W'((32'(vCount) >> BG_SHIFT) * 32'(H_ACTIVE >> BG_SHIFT)
                                + (32'(hCount) >> BG_SHIFT));

  for (genvar g = 0; g < N_SPR; g++) begin : g_spr
    vga_sprite_unit #(
      .SPR_W  (SPR_W),
      .SPR_H  (SPR_H),
      .ADDR_W (SPR_ADDR_W)
    ) u_spr (
      .clk     (clk),
      .reset_n (reset_n),
      .load_i  (load_shadow),
      .en_i    (spr_en[g]),
      .x_i     (spr_x[g*10 +: 10]),
      .y_i     (spr_y[g*10 +: 10]),
      .h_i     (hCount),
      .v_i     (vCount),
      .hit_o   (hit[g]),
      .addr_o  (spr_addr[g*SPR_ADDR_W +: SPR_ADDR_W])
    );
  end

  // Walk from the highest index down so the lowest opaque index wins
  always_comb begin
    rgb_d = bg_data;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit[i] && (spr_data[i*COLOR_W +: COLOR_W] != KEY))
        rgb_d = spr_data[i*COLOR_W +: COLOR_W];
    end
    if (!bright_q)
      rgb_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bg_addr_q    <= '0;
      bright_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      bg_addr_q    <= bg_addr_d;
      bright_q     <= bright;
      frame_tick_q <= load_shadow;
      rgb_q        <= rgb_d;
    end
  end

  assign bg_addr    = bg_addr_q;
  assign rgb        = rgb_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: directed vector table, hand sequences for shadow
// timing and mid-frame reset, then randomized pixels against a pixel-rule model.
module tb_vga_layer_mixer;

  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bright;
  logic [9:0]  hCount, vCount;
  logic [19:0] spr_x, spr_y;
  logic [1:0]  spr_en;
  logic [18:0] bg_addr;
  logic [11:0] bg_data;
  logic [23:0] spr_addr;
  logic [23:0] spr_data;
  logic [11:0] rgb;
  logic        frame_tick;

  logic [1:0]  key_all;
  logic        pat_mode;

  int checks   = 0;
  int failures = 0;

  int m_x[2];
  int m_y[2];
  bit m_en[2];

  always #5 clk = ~clk;

  vga_layer_mixer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bright     (bright),
    .hCount     (hCount),
    .vCount     (vCount),
    .spr_x      (spr_x),
    .spr_y      (spr_y),
    .spr_en     (spr_en),
    .bg_addr    (bg_addr),
    .bg_data    (bg_data),
    .spr_addr   (spr_addr),
    .spr_data   (spr_data),
    .rgb        (rgb),
    .frame_tick (frame_tick)
  );

  function automatic logic [11:0] rom_bg(int a);
    return 12'((a * 13 + 7) & 'hFFF);
  endfunction

  function automatic logic [11:0] rom_spr(int i, int a, logic kall, logic pat);
    logic [11:0] val;
    if (kall) return KEY;
    if (pat && (a % 5 == 0)) return KEY;
    val = 12'((a * 37 + i * 1111 + 5) & 'hFFF);
    if (val == KEY) val = val ^ 12'h001;
    return val;
  endfunction

  assign bg_data  = rom_bg(int'(bg_addr));
  assign spr_data = {rom_spr(1, int'(spr_addr[23:12]), key_all[1], pat_mode),
                     rom_spr(0, int'(spr_addr[11:0]),  key_all[0], pat_mode)};

  // Pixel rule: lowest-index enabled sprite covering (h,v) with non-key data, else background
  function automatic int model_rgb(int h, int v, bit b, bit pat);
    if (!b) return 0;
    for (int i = 0; i < 2; i++) begin
      if (m_en[i] && h >= m_x[i] && h < m_x[i] + 64 && v >= m_y[i] && v < m_y[i] + 64) begin
        int d;
        d = int'(rom_spr(i, (v - m_y[i]) * 64 + (h - m_x[i]), 1'b0, pat));
        if (d != int'(KEY)) return d;
      end
    end
    return int'(rom_bg(v * 640 + h));
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(int c);
    case (c)
      0: begin spr_x = {10'd130, 10'd100}; spr_y = {10'd60, 10'd50}; spr_en = 2'b11; end
      1: begin spr_x = {10'd0, 10'd600};   spr_y = {10'd0, 10'd0};   spr_en = 2'b01; end
      default: begin spr_x = {10'd130, 10'd100}; spr_y = {10'd60, 10'd50}; spr_en = 2'b00; end
    endcase
  endtask

  task automatic do_load();
    hCount = 10'd0; vCount = 10'd480; bright = 1'b0;
    @(posedge clk); #1;
    chk("frame_tick_high", int'(frame_tick), 1);
    for (int i = 0; i < 2; i++) begin
      m_x[i]  = int'(spr_x[i*10 +: 10]);
      m_y[i]  = int'(spr_y[i*10 +: 10]);
      m_en[i] = spr_en[i];
    end
    hCount = 10'd1; vCount = 10'd0;
    @(posedge clk); #1;
    chk("frame_tick_low", int'(frame_tick), 0);
  endtask

  task automatic px_check(string name, int h, int v, bit b, int exp);
    hCount = 10'(h); vCount = 10'(v); bright = b;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk(name, int'(rgb), exp);
  endtask

  typedef struct {
    int cfg; int h; int v; bit b; bit k0; bit k1;
    int ea; int es0; int es1; int src;
  } vec_t;

  vec_t tbl[14];

  initial begin
    int cur_cfg;
    int exp_rgb;
    int prev_e;
    bit valid;

    // src: 0 background, 1 sprite0, 2 sprite1, 3 blanked
    tbl[0]  = '{2,  10,  20, 1'b1, 1'b0, 1'b0, 12810,    0,    0, 0};
    tbl[1]  = '{0, 100,  50, 1'b1, 1'b0, 1'b0, 32100,    0,    0, 1};
    tbl[2]  = '{0, 163, 113, 1'b1, 1'b0, 1'b0, 72483, 4095, 3425, 1};
    tbl[3]  = '{0, 164,  50, 1'b1, 1'b0, 1'b0, 32164,    0,    0, 0};
    tbl[4]  = '{0, 140,  70, 1'b1, 1'b0, 1'b0, 44940, 1320,  650, 1};
    tbl[5]  = '{0, 140,  70, 1'b1, 1'b1, 1'b0, 44940, 1320,  650, 2};
    tbl[6]  = '{0, 140,  70, 1'b1, 1'b1, 1'b1, 44940, 1320,  650, 0};
    tbl[7]  = '{0, 140,  70, 1'b0, 1'b0, 1'b0, 44940, 1320,  650, 3};
    tbl[8]  = '{0, 100,  49, 1'b1, 1'b0, 1'b0, 31460,    0,    0, 0};
    tbl[9]  = '{0,  99,  50, 1'b1, 1'b0, 1'b0, 32099,    0,    0, 0};
    tbl[10] = '{0, 163, 114, 1'b1, 1'b0, 1'b0, 73123,    0, 3489, 2};
    tbl[11] = '{1, 639,  10, 1'b1, 1'b0, 1'b0,  7039,  679,    0, 1};
    tbl[12] = '{1,   0,  10, 1'b1, 1'b0, 1'b0,  6400,    0,    0, 0};
    tbl[13] = '{1, 599,  10, 1'b1, 1'b0, 1'b0,  6999,    0,    0, 0};

    reset_n = 1'b0; bright = 1'b0; hCount = '0; vCount = '0;
    spr_x = '0; spr_y = '0; spr_en = '0; key_all = '0; pat_mode = 1'b0;
    for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; end

    #12;
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_bg_addr", int'(bg_addr), 0);
    chk("reset_spr_addr", int'(spr_addr), 0);
    chk("reset_frame_tick", int'(frame_tick), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    cur_cfg = -1;
    for (int n = 0; n < 14; n++) begin
      if (tbl[n].cfg != cur_cfg) begin
        set_cfg(tbl[n].cfg);
        do_load();
        cur_cfg = tbl[n].cfg;
      end
      key_all = {tbl[n].k1, tbl[n].k0};
      hCount  = 10'(tbl[n].h);
      vCount  = 10'(tbl[n].v);
      bright  = tbl[n].b;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_bg_addr", n), int'(bg_addr), tbl[n].ea);
      chk($sformatf("vec%0d_spr_addr0", n), int'(spr_addr[11:0]), tbl[n].es0);
      chk($sformatf("vec%0d_spr_addr1", n), int'(spr_addr[23:12]), tbl[n].es1);
      @(posedge clk); #1;
      case (tbl[n].src)
        0:       exp_rgb = int'(rom_bg(tbl[n].ea));
        1:       exp_rgb = int'(rom_spr(0, tbl[n].es0, tbl[n].k0, 1'b0));
        2:       exp_rgb = int'(rom_spr(1, tbl[n].es1, tbl[n].k1, 1'b0));
        default: exp_rgb = 0;
      endcase
      chk($sformatf("vec%0d_rgb", n), int'(rgb), exp_rgb);
    end
    key_all = '0;

    // Mid-frame position change must wait for the next shadow load
    set_cfg(0);
    do_load();
    px_check("line200_before", 5, 200, 1'b1, int'(rom_bg(200 * 640 + 5)));
    spr_x[9:0] = 10'd300;
    px_check("midframe_old_pos", 100, 50, 1'b1, int'(rom_spr(0, 0, 1'b0, 1'b0)));
    px_check("midframe_new_pos_idle", 300, 50, 1'b1, int'(rom_bg(50 * 640 + 300)));
    do_load();
    px_check("nextframe_old_pos", 100, 50, 1'b1, int'(rom_bg(32100)));
    px_check("nextframe_new_pos", 300, 50, 1'b1, int'(rom_spr(0, 0, 1'b0, 1'b0)));

    // Mid-line reset clears outputs at once and drops the shadow sprites
    hCount = 10'd300; vCount = 10'd50; bright = 1'b1;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midreset_rgb", int'(rgb), 0);
    chk("midreset_spr_addr", int'(spr_addr), 0);
    chk("midreset_bg_addr", int'(bg_addr), 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin m_x[i] = 0; m_y[i] = 0; m_en[i] = 0; end
    px_check("postreset_bg_only", 300, 50, 1'b1, int'(rom_bg(32100 + 200)));
    px_check("postreset_bg_only2", 140, 70, 1'b1, int'(rom_bg(44940)));
    do_load();
    px_check("postreset_after_load", 300, 50, 1'b1, int'(rom_spr(0, 0, 1'b0, 1'b0)));

    // Randomized pixels with periodic shadow loads and input reshuffles
    pat_mode = 1'b1;
    valid    = 1'b0;
    prev_e   = 0;
    for (int c = 0; c < 4000; c++) begin
      int h, v, e, ea, k, t;
      bit b, ld;
      if (c % 97 == 0) begin
        for (int i = 0; i < 2; i++) begin
          spr_x[i*10 +: 10] = 10'($urandom_range(0, 639));
          spr_y[i*10 +: 10] = 10'($urandom_range(0, 479));
          spr_en[i]         = ($urandom_range(0, 3) != 0);
        end
      end
      ld = (c % 150 == 149);
      b  = ($urandom_range(0, 7) != 0);
      if (ld) begin
        h = 0; v = 480;
      end else if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(0, 1));
        t = m_x[k] + int'($urandom_range(0, 80)) - 8;
        h = (t < 0) ? 0 : ((t > 639) ? 639 : t);
        t = m_y[k] + int'($urandom_range(0, 80)) - 8;
        v = (t < 0) ? 0 : ((t > 479) ? 479 : t);
      end else begin
        h = int'($urandom_range(0, 639));
        v = int'($urandom_range(0, 479));
      end
      hCount = 10'(h); vCount = 10'(v); bright = b;
      e  = model_rgb(h, v, b, 1'b1);
      ea = v * 640 + h;
      @(posedge clk); #1;
      chk("rand_bg_addr", int'(bg_addr), ea);
      chk("rand_frame_tick", int'(frame_tick), ld ? 1 : 0);
      if (valid) chk("rand_rgb", int'(rgb), prev_e);
      prev_e = e;
      valid  = 1'b1;
      if (ld) begin
        for (int i = 0; i < 2; i++) begin
          m_x[i]  = int'(spr_x[i*10 +: 10]);
          m_y[i]  = int'(spr_y[i*10 +: 10]);
          m_en[i] = spr_en[i];
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_layer_mixer.md
VGA_LAYER_MIXER -- requirements
Module: vga_layer_mixer

Interface
REQ-001 SHALL have parameter COLOR_W, default 12: RGB pixel width.
REQ-002 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 SHALL have parameter BG_SHIFT, default 0: background downscale exponent (0..2).
REQ-005 SHALL have parameter N_SPR, default 2: sprite layer count (1..4).
REQ-006 SHALL have parameter SPR_W, default 64: sprite width in pixels.
REQ-007 SHALL have parameter SPR_H, default 64: sprite height in pixels.
REQ-008 SHALL have parameter KEY, default 12'hF0F: transparent color.
REQ-009 SHALL have port clk, input, 1: the single clock.
REQ-010 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-011 SHALL have port bright, input, 1: active-video flag.
REQ-012 SHALL have ports hCount and vCount, input, 10 each: pixel coordinates.
REQ-013 SHALL have port spr_x, input, N_SPR*10: packed sprite left edges.
REQ-014 SHALL have port spr_y, input, N_SPR*10: packed sprite top edges.
REQ-015 SHALL have port spr_en, input, N_SPR: per-sprite enable.
REQ-016 SHALL have port bg_addr, output, BG_AW: background ROM address.
REQ-017 SHALL have port bg_data, input, COLOR_W: background ROM data, sync ROM, 1-cycle latency.
REQ-018 SHALL have port spr_addr, output, N_SPR*SPR_AW: sprite ROM addresses.
REQ-019 SHALL have port spr_data, input, N_SPR*COLOR_W: sprite ROM data, 1-cycle latency.
REQ-020 SHALL have port rgb, output, COLOR_W: registered pixel color.
REQ-021 SHALL have port frame_tick, output, 1: one-cycle pulse when shadow registers load.

Function
REQ-022 Stage 1 SHALL register bg_addr, spr_addr, per-sprite hit flags and bright from current hCount/vCount.
REQ-023 bg_addr SHALL equal (vCount>>BG_SHIFT)*(H_ACTIVE>>BG_SHIFT)+(hCount>>BG_SHIFT).
REQ-024 Sprite i hit SHALL be asserted iff shadow enable i, x_i<=hCount<x_i+SPR_W, y_i<=vCount<y_i+SPR_H, all compares 11-bit.
REQ-025 On hit, spr_addr i SHALL equal (vCount-y_i)*SPR_W+(hCount-x_i); on miss it SHALL be 0.
REQ-026 Stage 2 SHALL composite: first sprite, lowest index first, with hit and data!=KEY; else bg_data.
REQ-027 rgb SHALL be 0 when the bright delayed to stage 2 is low.
REQ-028 Latency SHALL be exactly 2 cycles from hCount/vCount/bright to rgb.
REQ-029 spr_x/spr_y/spr_en SHALL be sampled into shadow registers only on the cycle hCount==0 and vCount==V_ACTIVE; frame_tick SHALL pulse 1 cycle later.
REQ-030 Mid-frame input changes SHALL not affect rgb until the next shadow load.
REQ-031 Sprites crossing the right or bottom edge SHALL render clipped, with no wrap to column or line 0.
REQ-032 Every sprite pixel equal to KEY SHALL expose the next layer.

Reset
REQ-033 reset_n low SHALL asynchronously clear rgb, bg_addr, spr_addr, hit flags, pipelined bright, shadow registers and frame_tick to 0.
REQ-034 After mid-frame reset, output SHALL be background-only until the first shadow load.

Structure
REQ-035 Package vga_mixer_pkg SHALL hold BG_AW=clog2((H_ACTIVE>>BG_SHIFT)*(V_ACTIVE>>BG_SHIFT)), SPR_AW=clog2(SPR_W*SPR_H) and the default KEY.
REQ-036 Sub-module vga_sprite_unit SHALL hold one sprite's shadow registers, hit test and address generation, instantiated N_SPR times.

Verification
REQ-037 Reset released, bright=1, (h,v)=(10,20), BG_SHIFT=0 -> bg_addr=12810 after 1 cycle; rgb=bg_data after 2 cycles; sprites disabled.
REQ-038 Sprite 0 at (100,50) enabled and loaded; pixel (100,50) -> spr_addr0=0; pixel (163,113) -> 4095; pixel (164,50) -> miss.
REQ-039 Sprites 0 and 1 overlap, both opaque -> rgb=sprite0 data; sprite0 data=12'hF0F -> rgb=sprite1 data.
REQ-040 spr_x changed at line 200 -> no change until vCount=480,hCount=0; frame_tick at the following cycle; new position from the next frame.
REQ-041 Sprite at x=600 -> columns 600..639 drawn, column 0 shows background; bright=0 -> rgb=0.
REQ-042 reset_n pulsed low mid-line -> rgb=0 immediately; next frame shows background only until frame_tick.
